// File: rtl/launch_seq_pkg.sv
// launch_seq_pkg: shared types and helpers for the launch sequencer.
//   state_t       - sequencer FSM states (IDLE, RUN, DRAIN, FINISH)
//   credit_width  - bits needed to count 0..MAX_OUTSTANDING in-flight iterations
package launch_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  function automatic int credit_width(input int max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

endpackage

// File: rtl/launch_credit_counter.sv
// launch_credit_counter: up/down counter of issued-but-not-completed iterations.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_clr             synchronous clear (new run or watchdog abort)
//   i_inc, i_dec      one credit taken / returned; both together leave the count unchanged
//   o_count           current outstanding count
//   o_full, o_empty   count == MAX_OUTSTANDING / count == 0
module launch_credit_counter
  import launch_seq_pkg::*;
#(
  parameter  int MAX_OUTSTANDING = 2,
  localparam int W               = credit_width(MAX_OUTSTANDING)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_full,
  output logic         o_empty
);

  localparam logic [W-1:0] ONE     = W'(1);
  localparam logic [W-1:0] MAX_CNT = W'(MAX_OUTSTANDING);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else begin
      case ({i_inc, i_dec})
        2'b10:   r_count <= r_count + ONE;
        2'b01:   r_count <= r_count - ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_full  = (r_count == MAX_CNT);
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/launch_sequencer.sv
// launch_sequencer: turns one "run N iterations" command into N AXI4-Stream start
// tokens (tdata = iteration index), bounded by a credit of MAX_OUTSTANDING
// in-flight iterations, and reports completion once N done tokens have returned.
// Ports:
//   aclk, areset                 clock, asynchronous active-high reset
//   cmd_start, cmd_iterations    run request (accepted only in IDLE)
//   busy, done_pulse             run active / one-cycle completion pulse
//   err_timeout                  sticky watchdog error
//   iter_completed               done tokens counted in the current/last run
//   m_start_axis_*               start token master (tstrb all ones, tlast = 1)
//   s_done_axis_*                done token slave (only tvalid is used)
//   o_dbg_state                  FSM state, for observation
//   o_dbg_outstanding            current in-flight iteration count
// Build option: define LAUNCH_SEQ_TIMEOUT_EN to build the watchdog; otherwise
// err_timeout is tied low and TIMEOUT_CYCLES is unused.
//
// Handshake: a token moves on a cycle where tvalid && tready are both high at
// the clock edge. Once the start tvalid is high it stays high with tdata held
// until the transfer (only areset or a watchdog abort drops it). The done
// slave is always ready out of reset.
module launch_sequencer
  import launch_seq_pkg::*;
#(
  parameter  int C_AXIS_TDATA_WIDTH = 32,
  parameter  int CNT_WIDTH          = 32,
  parameter  int MAX_OUTSTANDING    = 2,
  parameter  int TIMEOUT_CYCLES     = 1000000,
  localparam int CW                 = credit_width(MAX_OUTSTANDING)
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            cmd_start,
  input  logic [CNT_WIDTH-1:0]            cmd_iterations,
  output logic                            busy,
  output logic                            done_pulse,
  output logic                            err_timeout,
  output logic [CNT_WIDTH-1:0]            iter_completed,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_start_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_start_axis_tstrb,
  output logic                            m_start_axis_tvalid,
  input  logic                            m_start_axis_tready,
  output logic                            m_start_axis_tlast,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_done_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_done_axis_tstrb,
  input  logic                            s_done_axis_tvalid,
  output logic                            s_done_axis_tready,
  input  logic                            s_done_axis_tlast,
  output state_t                          o_dbg_state,
  output logic [CW-1:0]                   o_dbg_outstanding
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam int MW = (C_AXIS_TDATA_WIDTH > CNT_WIDTH) ? C_AXIS_TDATA_WIDTH : CNT_WIDTH;

  state_t               r_state, w_state_next;
  logic [CNT_WIDTH-1:0] r_n, r_issued, r_completed;
  logic                 r_zero_pulse;
  logic [CW-1:0]        w_outstanding;
  logic                 w_full, w_empty;
  logic                 w_active, w_tvalid, w_start_hs, w_done_hs;
  logic                 w_cmd_acc, w_cmd_zero, w_timeout;
  logic [MW-1:0]        w_issued_ext;
  logic                 w_unused;

  assign w_unused = ^{s_done_axis_tdata, s_done_axis_tstrb, s_done_axis_tlast};

  assign w_active   = (r_state == RUN) || (r_state == DRAIN);
  // tvalid is a function of registered state only; issued/full change only on a
  // transfer, so once raised it cannot fall before the handshake.
  assign w_tvalid   = (r_state == RUN) && (r_issued != r_n) && !w_full;
  assign w_start_hs = w_tvalid && m_start_axis_tready;
  // Done tokens with nothing in flight or beyond N are dropped, which also keeps
  // the credit counter from underflowing on a stray token.
  assign w_done_hs  = s_done_axis_tvalid && s_done_axis_tready && w_active &&
                      !w_empty && (r_completed != r_n);
  assign w_cmd_acc  = (r_state == IDLE) && cmd_start && (cmd_iterations != '0);
  assign w_cmd_zero = (r_state == IDLE) && cmd_start && (cmd_iterations == '0);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = (r_state != IDLE);
    done_pulse   = (r_state == FINISH) || r_zero_pulse;
    case (r_state)
      IDLE:    if (w_cmd_acc) w_state_next = RUN;
      RUN:     if (w_start_hs && (r_issued + CNT_ONE == r_n)) w_state_next = DRAIN;
      DRAIN:   if (w_done_hs && (r_completed + CNT_ONE == r_n)) w_state_next = FINISH;
      FINISH:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (w_timeout) w_state_next = IDLE;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_n          <= '0;
      r_issued     <= '0;
      r_completed  <= '0;
      r_zero_pulse <= 1'b0;
    end else begin
      r_zero_pulse <= w_cmd_zero;
      if (w_cmd_acc) begin
        r_n         <= cmd_iterations;
        r_issued    <= '0;
        r_completed <= '0;
      end else begin
        if (w_start_hs) r_issued    <= r_issued + CNT_ONE;
        if (w_done_hs)  r_completed <= r_completed + CNT_ONE;
      end
    end
  end

  launch_credit_counter #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_credit (
    .i_clk   (aclk),
    .i_rst   (areset),
    .i_clr   (w_cmd_acc | w_timeout),
    .i_inc   (w_start_hs),
    .i_dec   (w_done_hs),
    .o_count (w_outstanding),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef LAUNCH_SEQ_TIMEOUT_EN
  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  logic [WD_W-1:0] r_wd;
  logic            r_err;
  logic            w_wd_run;

  // Counts cycles spent waiting on in-flight work; any returned token restarts it.
  assign w_wd_run  = w_active && !w_empty && !w_done_hs;
  assign w_timeout = w_wd_run && (r_wd == WD_LAST);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      if (!w_wd_run || w_timeout) r_wd <= '0;
      else                        r_wd <= r_wd + WD_ONE;
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign err_timeout = r_err;
`else
  localparam int UNUSED_TIMEOUT = TIMEOUT_CYCLES;
  assign w_timeout   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign w_issued_ext        = MW'(r_issued);
  assign m_start_axis_tdata  = w_issued_ext[C_AXIS_TDATA_WIDTH-1:0];
  assign m_start_axis_tstrb  = '1;
  assign m_start_axis_tvalid = w_tvalid;
  assign m_start_axis_tlast  = 1'b1;
  assign s_done_axis_tready  = ~areset;
  assign iter_completed      = r_completed;
  assign o_dbg_state         = r_state;
  assign o_dbg_outstanding   = w_outstanding;

endmodule

// File: tb/tb_launch_sequencer.sv
// tb_launch_sequencer: self-checking bench for launch_sequencer.
// A run-level reference model (busy window, expected token indices, pending
// done returns, in-flight count) is advanced once per cycle from the
// handshakes seen on the ports and compared against the outputs.
module tb_launch_sequencer;
  import launch_seq_pkg::*;

  localparam int TDW  = 32;
  localparam int CNTW = 32;
  localparam int MAXO = 2;
  localparam int TMO  = 50;
  localparam int CW   = credit_width(MAXO);
  localparam int HUGE = 32'h3fffffff;

  // ---------------- clock / reset / DUT ----------------
  logic              aclk = 1'b0;
  logic              areset;
  logic              cmd_start;
  logic [CNTW-1:0]   cmd_iterations;
  logic              busy, done_pulse, err_timeout;
  logic [CNTW-1:0]   iter_completed;
  logic [TDW-1:0]    m_start_axis_tdata;
  logic [TDW/8-1:0]  m_start_axis_tstrb;
  logic              m_start_axis_tvalid, m_start_axis_tready, m_start_axis_tlast;
  logic [TDW-1:0]    s_done_axis_tdata;
  logic [TDW/8-1:0]  s_done_axis_tstrb;
  logic              s_done_axis_tvalid, s_done_axis_tready, s_done_axis_tlast;
  state_t            dbg_state;
  logic [CW-1:0]     dbg_outstanding;

  always #5 aclk = ~aclk;

  launch_sequencer #(
    .C_AXIS_TDATA_WIDTH(TDW), .CNT_WIDTH(CNTW),
    .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .aclk(aclk), .areset(areset),
    .cmd_start(cmd_start), .cmd_iterations(cmd_iterations),
    .busy(busy), .done_pulse(done_pulse), .err_timeout(err_timeout),
    .iter_completed(iter_completed),
    .m_start_axis_tdata(m_start_axis_tdata), .m_start_axis_tstrb(m_start_axis_tstrb),
    .m_start_axis_tvalid(m_start_axis_tvalid), .m_start_axis_tready(m_start_axis_tready),
    .m_start_axis_tlast(m_start_axis_tlast),
    .s_done_axis_tdata(s_done_axis_tdata), .s_done_axis_tstrb(s_done_axis_tstrb),
    .s_done_axis_tvalid(s_done_axis_tvalid), .s_done_axis_tready(s_done_axis_tready),
    .s_done_axis_tlast(s_done_axis_tlast),
    .o_dbg_state(dbg_state), .o_dbg_outstanding(dbg_outstanding)
  );

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int errors = 0;
  logic [TDW-1:0] exp_q[$];   // token indices still to be issued, in order
  int ret_q[$];               // cycle at which each in-flight token's done returns
  int cyc = 0;
  int m_n = 0, m_issued = 0, m_completed = 0, m_out = 0;
  int m_busy_start = 1, m_busy_end = 0, m_zero_pulse = -1;
  int start_cnt = 0, pulses = 0, sim_seen = 0, max_out_seen = 0;
  int dly_min = 3, dly_max = 3, tready_mode = 0;
  bit chk_en = 1'b1, suppress_done = 1'b0, pend_cmd = 1'b0;
  int pend_n = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    ret_q.delete();
    m_n = 0; m_issued = 0; m_completed = 0; m_out = 0;
    m_busy_start = 1; m_busy_end = 0; m_zero_pulse = -1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge aclk); #1;
    areset = 1'b1;
    cmd_start = 1'b0; cmd_iterations = '0;
    m_start_axis_tready = 1'b0; s_done_axis_tvalid = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done_pulse", done_pulse, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_iter_completed", iter_completed, 0);
    check("rst_tvalid", m_start_axis_tvalid, 0);
    check("rst_tdata", m_start_axis_tdata, 0);
    check("rst_done_tready", s_done_axis_tready, 0);
    check("rst_outstanding", dbg_outstanding, 0);
    check("rst_state", dbg_state, IDLE);
    model_reset();
    @(posedge aclk); #1;
    areset = 1'b0;
  endtask

  // One clock: drive inputs at posedge+1, observe at posedge+2, then advance the model.
  task automatic cycle();
    bit busy_m, done_hs, start_hs;
    int t;
    @(posedge aclk); #1;
    cyc++;
    cmd_start      = pend_cmd;
    cmd_iterations = pend_n;
    pend_cmd       = 1'b0;
    case (tready_mode)
      0:       m_start_axis_tready = 1'b1;
      1:       m_start_axis_tready = 1'($urandom_range(0, 1));
      default: m_start_axis_tready = 1'b0;
    endcase
    s_done_axis_tvalid = (ret_q.size() != 0) && (ret_q[0] <= cyc);
    s_done_axis_tdata  = $urandom;
    s_done_axis_tstrb  = 4'($urandom);
    s_done_axis_tlast  = 1'($urandom);
    #1;
    busy_m = (cyc >= m_busy_start) && (cyc <= m_busy_end);
    if (chk_en) begin
      check("busy", busy, busy_m);
      check("done_pulse", done_pulse, (cyc == m_busy_end) || (cyc == m_zero_pulse));
      check("tvalid", m_start_axis_tvalid, busy_m && (m_issued < m_n) && (m_out < MAXO));
      check("outstanding", dbg_outstanding, m_out);
      check("iter_completed", iter_completed, m_completed);
      check("done_tready", s_done_axis_tready, 1);
      check("err_timeout", err_timeout, 0);
      if (m_start_axis_tvalid === 1'b1 && exp_q.size() != 0)
        check("tdata_hold", m_start_axis_tdata, exp_q[0]);
    end
    done_hs  = ((s_done_axis_tvalid && s_done_axis_tready) === 1'b1);
    start_hs = ((m_start_axis_tvalid && m_start_axis_tready) === 1'b1);
    if (done_hs) begin
      void'(ret_q.pop_front());
      m_out--;
      m_completed++;
      if (m_completed == m_n) m_busy_end = cyc + 1;
    end
    if (start_hs) begin
      start_cnt++;
      if (exp_q.size() == 0) check("start_unexpected", m_start_axis_tvalid, 0);
      else                   check("tdata", m_start_axis_tdata, exp_q.pop_front());
      m_issued++;
      m_out++;
      if (m_out > max_out_seen) max_out_seen = m_out;
      if (!suppress_done) begin
        t = cyc + $urandom_range(dly_min, dly_max);
        if (ret_q.size() != 0 && ret_q[$] > t) t = ret_q[$];
        ret_q.push_back(t);
      end
    end
    if (done_hs && start_hs) sim_seen++;
    if (done_pulse === 1'b1) pulses++;
    if (cmd_start && !busy_m) begin
      if (cmd_iterations != 0) begin
        m_n = cmd_iterations; m_issued = 0; m_completed = 0;
        m_busy_start = cyc + 1; m_busy_end = HUGE;
        for (int i = 0; i < m_n; i++) exp_q.push_back(i);
      end else begin
        m_zero_pulse = cyc + 1;
      end
    end
  endtask

  task automatic send_cmd(input int n);
    pend_cmd = 1'b1;
    pend_n   = n;
  endtask

  task automatic run_until_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      cycle();
      if (m_busy_end != HUGE && cyc >= m_busy_end && ret_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, ok, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  // ---------------- directed + randomized sequence ----------------
  initial begin
    int p0, s0, n, h, errc;
    bit found;
    areset = 1'b1;
    cmd_start = 1'b0; cmd_iterations = '0;
    m_start_axis_tready = 1'b0;
    s_done_axis_tvalid = 1'b0; s_done_axis_tdata = '0;
    s_done_axis_tstrb = '0; s_done_axis_tlast = 1'b0;
    do_reset();

    // N=5, tready high, done tokens 3 cycles after each start.
    tready_mode = 0; dly_min = 3; dly_max = 3;
    p0 = pulses; max_out_seen = 0;
    send_cmd(5);
    run_until_idle("t1_finish");
    check("t1_iter_completed", iter_completed, 5);
    check("t1_pulses", pulses - p0, 1);
    check("t1_max_outstanding", max_out_seen, MAXO);
    check("t1_tlast", m_start_axis_tlast, 1);
    check("t1_tstrb", m_start_axis_tstrb, 4'hf);

    // tready held low after tvalid rises; token must wait unchanged.
    tready_mode = 2;
    send_cmd(1);
    cycle();
    cycle();
    check("t2_tvalid_rise", m_start_axis_tvalid, 1);
    repeat (10) cycle();
    check("t2_tvalid_held", m_start_axis_tvalid, 1);
    check("t2_tdata_held", m_start_axis_tdata, 0);
    tready_mode = 0;
    s0 = start_cnt;
    cycle();
    check("t2_transfer", start_cnt - s0, 1);
    run_until_idle("t2_finish");
    check("t2_iter_completed", iter_completed, 1);

    // Done returns 2 cycles after start: credit return and new issue coincide.
    dly_min = 2; dly_max = 2;
    s0 = sim_seen;
    send_cmd(6);
    run_until_idle("t3_finish");
    check("t3_simultaneous_seen", sim_seen > s0, 1);
    check("t3_iter_completed", iter_completed, 6);

    // Randomized runs: random N, random tready, random done latency.
    tready_mode = 1; dly_min = 1; dly_max = 6;
    repeat (4) begin
      n = $urandom_range(1, 12);
      send_cmd(n);
      run_until_idle("t4_finish");
      check("t4_iter_completed", iter_completed, n);
    end

    // N=0 pulses done without a run; a command during a busy run is ignored.
    tready_mode = 0; dly_min = 3; dly_max = 3;
    s0 = start_cnt;
    send_cmd(0);
    cycle();
    cycle();
    check("t5_zero_pulse", done_pulse, 1);
    check("t5_zero_busy", busy, 0);
    cycle();
    check("t5_zero_pulse_once", done_pulse, 0);
    check("t5_zero_no_tokens", start_cnt - s0, 0);
    send_cmd(3);
    cycle();
    cycle();
    send_cmd(7);
    run_until_idle("t5_finish");
    check("t5_iter_completed", iter_completed, 3);
    check("t5_token_count", start_cnt - s0, 3);

    // Reset with one token outstanding, then a clean N=1 run.
    dly_min = 10; dly_max = 10;
    send_cmd(3);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (m_out == 1) begin found = 1'b1; break; end
    end
    check("t6_one_outstanding", found, 1);
    do_reset();
    dly_min = 3; dly_max = 3;
    send_cmd(1);
    run_until_idle("t6_finish");
    check("t6_iter_completed", iter_completed, 1);

`ifdef LAUNCH_SEQ_TIMEOUT_EN
    // No done token ever returns: watchdog aborts without done_pulse.
    chk_en = 1'b0; suppress_done = 1'b1; tready_mode = 0;
    s0 = start_cnt; h = -1; errc = -1;
    send_cmd(1);
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (start_cnt != s0) begin h = cyc; break; end
    end
    check("t7_token_issued", start_cnt - s0, 1);
    p0 = pulses;
    for (int i = 0; i < 120; i++) begin
      cycle();
      if (err_timeout === 1'b1) begin errc = cyc; break; end
    end
    check("t7_err_cycle", errc, h + TMO + 1);
    check("t7_err", err_timeout, 1);
    check("t7_busy", busy, 0);
    check("t7_tvalid", m_start_axis_tvalid, 0);
    check("t7_state", dbg_state, IDLE);
    check("t7_no_pulse", pulses - p0, 0);
    cycle();
    check("t7_err_sticky", err_timeout, 1);
    check("t7_no_pulse_after", done_pulse, 0);
    do_reset();
    chk_en = 1'b1; suppress_done = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
